// File: rtl/video_generator_chunk_source.sv
`default_nettype none
// ============================================================================
// video_generator_chunk_source - serves {vPos, chunkNum} chunk requests from
// a pixel generator with credit-limited issue. Option: VIDEO_GEN_SOURCE_STATS_EN
// Revision: 1.0
// ============================================================================
module video_generator_chunk_source #(
  parameter int CHUNK_BITS    = 5,
  parameter int HACTIVE_BITS  = 11,
  parameter int VACTIVE_BITS  = 11,
  parameter int PIXEL_FORMAT  = 0,
  parameter int BUF_ADDR_BITS = 3,
  localparam int CHUNKNUM_BITS = HACTIVE_BITS - CHUNK_BITS,
  localparam int REQUEST_BITS  = VACTIVE_BITS + CHUNKNUM_BITS,
  localparam int BPP           = (PIXEL_FORMAT == 1) ? 24 : 16
) (
  input  logic                    scalerClock,
  input  logic                    reset,
  output logic                    requestFifoReadEnable,
  input  logic                    requestFifoEmpty,
  input  logic [REQUEST_BITS-1:0] requestFifoReadData,
  output logic                    responseFifoWriteEnable,
  input  logic                    responseFifoFull,
  output logic [BPP-1:0]          responseFifoWriteData,
  output logic [HACTIVE_BITS-1:0] hPos,
  output logic [VACTIVE_BITS-1:0] vPos,
  output logic                    dataEnable,
  input  logic [7:0]              r,
  input  logic [7:0]              g,
  input  logic [7:0]              b,
  input  logic                    dataEnableDelayed,
  output logic                    busy,
`ifdef VIDEO_GEN_SOURCE_STATS_EN
  output logic [15:0]             chunksServed,
  output logic [15:0]             stallCycles,
`endif
  output logic                    overflowError
);

  localparam int DEPTH = 1 << BUF_ADDR_BITS;
  localparam logic [BUF_ADDR_BITS:0] DEPTH_CREDITS = (BUF_ADDR_BITS+1)'(DEPTH);
  localparam logic [CHUNK_BITS-1:0] CHUNK_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [REQUEST_BITS-1:0] req_reg;
  logic [CHUNK_BITS-1:0]   pixel_count;
  logic [BUF_ADDR_BITS:0]  outstanding;
  logic                    credit_ok;
  logic                    issue;
  logic                    latch_req;

  logic [BPP-1:0]          mem [DEPTH];
  logic [BUF_ADDR_BITS:0]  wr_ptr;
  logic [BUF_ADDR_BITS:0]  rd_ptr;
  logic                    buf_empty;
  logic                    buf_full;
  logic                    buf_write;
  logic                    buf_read;
  logic [BPP-1:0]          packed_pixel;

  assign credit_ok = (outstanding < DEPTH_CREDITS);

  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next            = state;
    issue                 = 1'b0;
    latch_req             = 1'b0;
    requestFifoReadEnable = 1'b0;
    case (state)
      IDLE: begin
        if (!requestFifoEmpty) begin
          state_next = READ;
        end
      end
      READ: begin
        requestFifoReadEnable = 1'b1;
        state_next            = LATCH;
      end
      LATCH: begin
        latch_req  = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (pixel_count == CHUNK_LAST) begin
            state_next = requestFifoEmpty ? IDLE : READ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Position outputs are forced to zero whenever no pixel is being issued.
  assign dataEnable = issue;
  assign hPos = issue ? {req_reg[CHUNKNUM_BITS-1:0], pixel_count} : '0;
  assign vPos = issue ? req_reg[REQUEST_BITS-1:CHUNKNUM_BITS] : '0;

  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      req_reg     <= '0;
      pixel_count <= '0;
    end else begin
      if (latch_req) begin
        req_reg     <= requestFifoReadData;
        pixel_count <= '0;
      end else if (issue) begin
        pixel_count <= pixel_count + 1'b1;
      end
    end
  end

  // Credits track pixels issued to the generator but not yet popped from the buffer.
  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue, buf_read})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  generate
    if (PIXEL_FORMAT == 1) begin : g_rgb888
      assign packed_pixel = {r, g, b};
    end else begin : g_rgb565
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      assign r5 = (&r[7:3]) ? r[7:3] : 5'((r + 8'd4) >> 3);
      assign g6 = (&g[7:2]) ? g[7:2] : 6'((g + 8'd2) >> 2);
      assign b5 = (&b[7:3]) ? b[7:3] : 5'((b + 8'd4) >> 3);
      assign packed_pixel = {r5, g6, b5};
    end
  endgenerate

  assign buf_empty = (wr_ptr == rd_ptr);
  assign buf_full  = (wr_ptr[BUF_ADDR_BITS] != rd_ptr[BUF_ADDR_BITS]) &&
                     (wr_ptr[BUF_ADDR_BITS-1:0] == rd_ptr[BUF_ADDR_BITS-1:0]);
  assign buf_write = dataEnableDelayed && !buf_full;
  assign buf_read  = !buf_empty && !responseFifoFull;

  always_ff @(posedge scalerClock) begin
    if (buf_write) begin
      mem[wr_ptr[BUF_ADDR_BITS-1:0]] <= packed_pixel;
    end
  end

  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      responseFifoWriteEnable <= 1'b0;
      responseFifoWriteData   <= '0;
      overflowError           <= 1'b0;
    end else begin
      if (buf_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (buf_read) begin
        rd_ptr                <= rd_ptr + 1'b1;
        responseFifoWriteData <= mem[rd_ptr[BUF_ADDR_BITS-1:0]];
      end
      responseFifoWriteEnable <= buf_read;
      if (dataEnableDelayed && buf_full) begin
        overflowError <= 1'b1;
      end
    end
  end

  // Busy also covers the final registered push after the last pop.
  assign busy = (state != IDLE) || (outstanding != '0) || responseFifoWriteEnable;

`ifdef VIDEO_GEN_SOURCE_STATS_EN
  logic [CHUNK_BITS-1:0] out_count;

  always_ff @(posedge scalerClock or posedge reset) begin
    if (reset) begin
      out_count    <= '0;
      chunksServed <= '0;
      stallCycles  <= '0;
    end else begin
      if (responseFifoWriteEnable) begin
        out_count <= out_count + 1'b1;
        if (&out_count) begin
          chunksServed <= chunksServed + 16'd1;
        end
      end
      if ((state == ISSUE) && !credit_ok && (stallCycles != 16'hFFFF)) begin
        stallCycles <= stallCycles + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_generator_chunk_source.sv
`default_nettype none
// Bench for video_generator_chunk_source: request FIFO and 3-stage generator
// models, scoreboarded positions and pixels, plus an RGB888 instance.
module tb_video_generator_chunk_source;

  logic        scalerClock = 1'b0;
  logic        reset = 1'b1;
  logic        requestFifoReadEnable;
  logic        requestFifoEmpty = 1'b1;
  logic [16:0] requestFifoReadData = '0;
  logic        responseFifoWriteEnable;
  logic        responseFifoFull = 1'b0;
  logic [15:0] responseFifoWriteData;
  logic [10:0] hPos;
  logic [10:0] vPos;
  logic        dataEnable;
  logic [7:0]  r = '0;
  logic [7:0]  g = '0;
  logic [7:0]  b = '0;
  logic        dataEnableDelayed = 1'b0;
  logic        busy;
  logic        overflowError;

  logic        fmt_rden;
  logic        fmt_wren;
  logic        fmt_full = 1'b0;
  logic [23:0] fmt_data;
  logic [10:0] fmt_hpos;
  logic [10:0] fmt_vpos;
  logic        fmt_den;
  logic [7:0]  fmt_r = '0;
  logic [7:0]  fmt_g = '0;
  logic [7:0]  fmt_b = '0;
  logic        fmt_de = 1'b0;
  logic        fmt_busy;
  logic        fmt_ovf;
`ifdef VIDEO_GEN_SOURCE_STATS_EN
  logic [15:0] chunksServed;
  logic [15:0] stallCycles;
  logic [15:0] fmt_chunks;
  logic [15:0] fmt_stalls;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int issued = 0;
  int pushed = 0;

  logic [21:0] exp_pos_q [$];
  logic [15:0] exp_data_q [$];
  logic [16:0] req_q [$];
  int          issue_cyc [$];

  logic        fixed_mode = 1'b0;
  logic [23:0] fixed_rgb = '0;
  logic [2:0]  pipe_de = '0;
  logic [10:0] pipe_h [3];
  logic [10:0] pipe_v [3];
  logic [21:0] mon_pos;
  logic [15:0] mon_data;

  always #5 scalerClock = ~scalerClock;

  video_generator_chunk_source dut (
    .scalerClock(scalerClock), .reset(reset),
    .requestFifoReadEnable(requestFifoReadEnable), .requestFifoEmpty(requestFifoEmpty),
    .requestFifoReadData(requestFifoReadData),
    .responseFifoWriteEnable(responseFifoWriteEnable), .responseFifoFull(responseFifoFull),
    .responseFifoWriteData(responseFifoWriteData),
    .hPos(hPos), .vPos(vPos), .dataEnable(dataEnable),
    .r(r), .g(g), .b(b), .dataEnableDelayed(dataEnableDelayed),
    .busy(busy),
`ifdef VIDEO_GEN_SOURCE_STATS_EN
    .chunksServed(chunksServed), .stallCycles(stallCycles),
`endif
    .overflowError(overflowError)
  );

  video_generator_chunk_source #(.PIXEL_FORMAT(1)) dut_fmt (
    .scalerClock(scalerClock), .reset(reset),
    .requestFifoReadEnable(fmt_rden), .requestFifoEmpty(1'b1),
    .requestFifoReadData(17'd0),
    .responseFifoWriteEnable(fmt_wren), .responseFifoFull(fmt_full),
    .responseFifoWriteData(fmt_data),
    .hPos(fmt_hpos), .vPos(fmt_vpos), .dataEnable(fmt_den),
    .r(fmt_r), .g(fmt_g), .b(fmt_b), .dataEnableDelayed(fmt_de),
    .busy(fmt_busy),
`ifdef VIDEO_GEN_SOURCE_STATS_EN
    .chunksServed(fmt_chunks), .stallCycles(fmt_stalls),
`endif
    .overflowError(fmt_ovf)
  );

  function automatic logic [23:0] colour(input logic [10:0] h, input logic [10:0] v);
    if (fixed_mode) return fixed_rgb;
    return {h[7:0], h[10:3] ^ v[7:0], v[7:0] + {3'b000, h[4:0]}};
  endfunction

  function automatic logic [15:0] exp565(input logic [23:0] c);
    logic [8:0] rs, gs, bs;
    logic [4:0] r5, b5;
    logic [5:0] g6;
    rs = {1'b0, c[23:16]} + 9'd4;
    gs = {1'b0, c[15:8]} + 9'd2;
    bs = {1'b0, c[7:0]} + 9'd4;
    r5 = rs[8] ? 5'h1F : rs[7:3];
    g6 = gs[8] ? 6'h3F : gs[7:2];
    b5 = bs[8] ? 5'h1F : bs[7:3];
    return {r5, g6, b5};
  endfunction

  // Generator model: three-stage delay of position, colour derived from it.
  always @(negedge scalerClock) begin
    pipe_de = {pipe_de[1:0], dataEnable};
    pipe_h[2] = pipe_h[1]; pipe_h[1] = pipe_h[0]; pipe_h[0] = hPos;
    pipe_v[2] = pipe_v[1]; pipe_v[1] = pipe_v[0]; pipe_v[0] = vPos;
    dataEnableDelayed = pipe_de[2];
    {r, g, b} = colour(pipe_h[2], pipe_v[2]);
  end

  always @(negedge scalerClock) begin
    if (requestFifoReadEnable && !reset) begin
      if (req_q.size() != 0) requestFifoReadData = req_q.pop_front();
      requestFifoEmpty = (req_q.size() == 0);
    end
  end

  always @(negedge scalerClock) begin
    cycle++;
    if (!reset) begin
      if (dataEnable) begin
        issued++;
        issue_cyc.push_back(cycle);
        checks++;
        if (exp_pos_q.size() == 0) begin
          failures++;
          $display("FAIL issue_unexpected: got v=%0d h=%0d, required none", vPos, hPos);
        end else begin
          mon_pos = exp_pos_q.pop_front();
          if ({vPos, hPos} !== mon_pos) begin
            failures++;
            $display("FAIL issue_position: got v=%0d h=%0d, required v=%0d h=%0d",
                     vPos, hPos, mon_pos[21:11], mon_pos[10:0]);
          end
        end
      end
      if (responseFifoWriteEnable) begin
        pushed++;
        checks++;
        if (exp_data_q.size() == 0) begin
          failures++;
          $display("FAIL push_unexpected: got %h, required none", responseFifoWriteData);
        end else begin
          mon_data = exp_data_q.pop_front();
          if (responseFifoWriteData !== mon_data) begin
            failures++;
            $display("FAIL push_data: got %h, required %h", responseFifoWriteData, mon_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge scalerClock);
    #1;
  endtask

  task automatic push_req(input logic [10:0] v, input logic [5:0] c);
    logic [10:0] h;
    req_q.push_back({v, c});
    requestFifoEmpty = 1'b0;
    for (int p = 0; p < 32; p++) begin
      h = {c, 5'(p)};
      exp_pos_q.push_back({v, h});
      exp_data_q.push_back(exp565(colour(h, v)));
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_data_q.size() == 0 && exp_pos_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    repeat (3) tick();
    got = {dataEnable, requestFifoReadEnable, responseFifoWriteEnable, busy,
           overflowError, |responseFifoWriteData, |hPos, |vPos};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: output bit %0d got %b, required 0", i, got[i]);
      end
    end
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || requestFifoReadEnable !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b rden=%b, required 0 0", busy, requestFifoReadEnable);
    end
  endtask

  task automatic test_single_chunk();
    int i0, p0;
    bit ok;
    i0 = issued; p0 = pushed;
    push_req(11'd5, 6'd2);
    wait_drain(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_drain: got timeout, required drain"); end
    tick();
    checks++;
    if (issued - i0 != 32 || pushed - p0 != 32) begin
      failures++;
      $display("FAIL single_count: got issued=%0d pushed=%0d, required 32 32", issued - i0, pushed - p0);
    end
    checks++;
    if (busy !== 1'b0 || overflowError !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got busy=%b ovf=%b, required 0 0", busy, overflowError);
    end
  endtask

  task automatic test_rgb565_rounding();
    logic [23:0] cin [2];
    logic [15:0] cexp [2];
    bit ok, seen;
    cin[0] = 24'hFF017C; cexp[0] = 16'hF810;
    cin[1] = 24'hFCFEF3; cexp[1] = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      fixed_mode = 1'b1;
      fixed_rgb = cin[k];
      push_req(11'd7, 6'(k));
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        tick();
        if (responseFifoWriteEnable) begin
          seen = 1'b1;
          checks++;
          if (responseFifoWriteData !== cexp[k]) begin
            failures++;
            $display("FAIL rgb565_pack: got %h, required %h", responseFifoWriteData, cexp[k]);
          end
        end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL rgb565_push: got timeout, required push"); end
      wait_drain(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rgb565_drain: got timeout, required drain"); end
      fixed_mode = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int i0, p0, late;
    bit ok;
    i0 = issued; p0 = pushed; late = 0;
    push_req(11'd9, 6'd10);
    for (int i = 0; i < 100 && pushed - p0 < 5; i++) tick();
    responseFifoFull = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i >= 50 && dataEnable) late++;
    end
    checks++;
    if ((issued - i0) - (pushed - p0) != 8) begin
      failures++;
      $display("FAIL bp_outstanding: got %0d, required 8", (issued - i0) - (pushed - p0));
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL bp_issue_stopped: got %0d issues, required 0", late); end
`ifdef VIDEO_GEN_SOURCE_STATS_EN
    checks++;
    if (stallCycles < 16'd50) begin failures++; $display("FAIL bp_stall_count: got %0d, required >=50", stallCycles); end
`endif
    responseFifoFull = 1'b0;
    wait_drain(400, ok);
    checks++;
    if (!ok || overflowError !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got ok=%b ovf=%b, required 1 0", ok, overflowError);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    issue_cyc.delete();
    push_req(11'd1, 6'd0);
    push_req(11'd2, 6'd63);
    push_req(11'd3, 6'd33);
    wait_drain(800, ok);
    checks++;
    if (!ok || issue_cyc.size() != 96) begin
      failures++;
      $display("FAIL b2b_count: got ok=%b issues=%0d, required 1 96", ok, issue_cyc.size());
    end else begin
      for (int i = 1; i < 96; i++) begin
        d = issue_cyc[i] - issue_cyc[i-1];
        checks++;
        if (d != ((i % 32 == 0) ? 3 : 1)) begin
          failures++;
          $display("FAIL b2b_spacing: pixel %0d got %0d cycles, required %0d", i, d, (i % 32 == 0) ? 3 : 1);
        end
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int i0;
    bit ok, seen;
    i0 = issued;
    push_req(11'd4, 6'd5);
    for (int i = 0; i < 100 && issued - i0 < 10; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dataEnable !== 1'b0 || responseFifoWriteEnable !== 1'b0 || busy !== 1'b0 || hPos !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got de=%b wren=%b busy=%b h=%0d, required 0 0 0 0",
               dataEnable, responseFifoWriteEnable, busy, hPos);
    end
`ifdef VIDEO_GEN_SOURCE_STATS_EN
    checks++;
    if (chunksServed !== 16'd0 || stallCycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_stats: got %0d %0d, required 0 0", chunksServed, stallCycles);
    end
`endif
    exp_pos_q.delete(); exp_data_q.delete(); req_q.delete();
    requestFifoEmpty = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    push_req(11'd6, 6'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (dataEnable) begin
        seen = 1'b1;
        checks++;
        if (hPos !== 11'd32 || vPos !== 11'd6) begin
          failures++;
          $display("FAIL reset_mid_restart: got h=%0d v=%0d, required 32 6", hPos, vPos);
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL reset_mid_issue: got timeout, required issue"); end
    wait_drain(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_mid_drain: got timeout, required drain"); end
`ifdef VIDEO_GEN_SOURCE_STATS_EN
    tick();
    checks++;
    if (chunksServed !== 16'd1) begin failures++; $display("FAIL stats_chunks: got %0d, required 1", chunksServed); end
`endif
  endtask

  task automatic test_rgb888();
    bit seen;
    fmt_de = 1'b1;
    {fmt_r, fmt_g, fmt_b} = 24'h123456;
    tick();
    fmt_de = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (fmt_wren) begin
        seen = 1'b1;
        checks++;
        if (fmt_data !== 24'h123456) begin
          failures++;
          $display("FAIL rgb888_pack: got %h, required 123456", fmt_data);
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rgb888_push: got timeout, required push"); end
  endtask

  task automatic test_overflow();
    logic [23:0] want [$];
    logic [23:0] w;
    int n;
    tick();
    fmt_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fmt_de = 1'b1;
      {fmt_r, fmt_g, fmt_b} = {8'(8'h10 + i), 8'(8'h80 - i), 8'(i * 3)};
      want.push_back({fmt_r, fmt_g, fmt_b});
      tick();
    end
    checks++;
    if (fmt_ovf !== 1'b0) begin failures++; $display("FAIL ovf_at_depth: got %b, required 0", fmt_ovf); end
    {fmt_r, fmt_g, fmt_b} = 24'hDEAD00;
    tick();
    fmt_de = 1'b0;
    checks++;
    if (fmt_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b, required 1", fmt_ovf); end
    fmt_full = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fmt_wren) begin
        n++;
        checks++;
        if (want.size() == 0) begin
          failures++;
          $display("FAIL ovf_extra_push: got %h, required none", fmt_data);
        end else begin
          w = want.pop_front();
          if (fmt_data !== w) begin failures++; $display("FAIL ovf_data: got %h, required %h", fmt_data, w); end
        end
      end
    end
    checks++;
    if (n != 8 || fmt_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drain: got pushes=%0d ovf=%b, required 8 1", n, fmt_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single_chunk();
    test_rgb565_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_rgb888();
    test_overflow();
    checks++;
    if (overflowError !== 1'b0) begin failures++; $display("FAIL main_overflow: got %b, required 0", overflowError); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
